// File: rtl/mips_pkg.sv
// Shared fetch-side definitions for the instruction memory and its loader.
//   HALT_WORD  : encoding that terminates both a program load and execution
//   NOP_WORD   : value returned by the fetch path when no program is resident
//   load_state_e : loader FSM states
package mips_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bus bundle between the instruction memory and its two clients:
//   byte stream (debug unit): i_load_en, i_byte, i_byte_valid -> o_byte_ready
//   fetch (PC register/CPU) : i_PC -> o_instruction, o_halt_fetched
// slave  = the instruction memory, master = debug unit + fetch logic.
interface instr_mem_loader_if #(
  parameter int NBITS = 32
);

  logic             i_load_en;
  logic [7:0]       i_byte;
  logic             i_byte_valid;
  logic             o_byte_ready;
  logic [NBITS-1:0] i_PC;
  logic [NBITS-1:0] o_instruction;
  logic             o_halt_fetched;

  modport slave (
    input  i_load_en, i_byte, i_byte_valid, i_PC,
    output o_byte_ready, o_instruction, o_halt_fetched
  );

  modport master (
    output i_load_en, i_byte, i_byte_valid, i_PC,
    input  o_byte_ready, o_instruction, o_halt_fetched
  );

endinterface

// File: rtl/instr_ram.sv
// Word-organised instruction RAM: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write word address
//   i_wdata : write data
//   i_raddr : read word address
//   o_rdata : read data (combinational)
module instr_ram #(
  parameter  int NBITS     = 32,
  parameter  int MEM_DEPTH = 256,
  localparam int ADDR_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [NBITS-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [NBITS-1:0]     o_rdata
);

  logic [NBITS-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory for the fetch stage with a byte-stream program loader.
// The debug unit streams bytes (big-endian within a word); every four bytes
// are committed as one word, sequentially from word 0. A HALT word ends the
// load; filling the memory without a HALT flags an error. Fetches return NOP
// until a complete program is resident.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)      : byte stream handshake and fetch port
//   o_load_done      : sticky, program terminated by HALT is resident
//   o_load_error     : sticky, memory filled without HALT
//   o_word_count     : words written in the current/last load
module instr_mem_loader #(
  parameter  int               NBITS     = 32,
  parameter  int               MEM_DEPTH = 256,
  parameter  logic [NBITS-1:0] HALT_WORD = mips_pkg::HALT_WORD,
  localparam int               ADDR_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  instr_mem_loader_if.slave    bus,
  output logic                 o_load_done,
  output logic                 o_load_error,
  output logic [ADDR_BITS:0]   o_word_count
);

  import mips_pkg::*;

  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(MEM_DEPTH);

  load_state_e          state_q, state_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [NBITS-1:0]     word_q, word_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 ram_we;
  logic [NBITS-1:0]     ram_rdata;
  logic [ADDR_BITS-1:0] raddr;
  logic                 pc_oob;
  logic [NBITS-1:0]     instr;
  logic                 unused_pc_lsb;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    count_d    = count_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      IDLE: begin
        if (bus.i_load_en) begin
          state_d    = LOAD;
          byte_idx_d = '0;
          count_d    = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      LOAD: begin
        // Dropping load enable abandons any partially assembled word.
        if (!bus.i_load_en) begin
          state_d = IDLE;
        end else if (bus.i_byte_valid) begin
          // Shifting left puts the first byte of the word in the MSBs.
          word_d     = {word_q[NBITS-9:0], bus.i_byte};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Commit always completes, regardless of load enable.
        count_d    = count_q + 1'b1;
        byte_idx_d = '0;
        if (word_q == HALT_WORD) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (count_d == DEPTH_CNT) begin
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        if (!bus.i_load_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Assembly register needs no reset: four shifts fully overwrite it.
  always_ff @(posedge i_clk) begin
    word_q <= word_d;
  end

  assign ram_we = (state_q == WRITE);

  instr_ram #(
    .NBITS     (NBITS),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (count_q[ADDR_BITS-1:0]),
    .i_wdata (word_q),
    .i_raddr (raddr),
    .o_rdata (ram_rdata)
  );

  // Fetch path: PC is a byte address, low two bits select nothing.
  assign raddr         = bus.i_PC[ADDR_BITS+1:2];
  assign pc_oob        = |bus.i_PC[NBITS-1:ADDR_BITS+2];
  assign unused_pc_lsb = ^bus.i_PC[1:0];

  // A runaway PC fetches HALT so the CPU stops instead of executing junk.
  always_comb begin
    if (!done_q) begin
      instr = NBITS'(NOP_WORD);
    end else if (pc_oob) begin
      instr = HALT_WORD;
    end else begin
      instr = ram_rdata;
    end
  end

  assign bus.o_instruction  = instr;
  assign bus.o_halt_fetched = (instr == HALT_WORD);
  assign bus.o_byte_ready   = (state_q == LOAD);

  assign o_load_done  = done_q;
  assign o_load_error = error_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 256-word instance for loading, fetching,
// backpressure, abort, random programs and reset, plus a 4-word instance
// for the memory-full case.
module tb_instr_mem_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.NBITS(32)) bi ();
  instr_mem_loader_if #(.NBITS(32)) si ();

  logic       done_b, err_b;
  logic [8:0] cnt_b;
  logic       done_s, err_s;
  logic [2:0] cnt_s;

  instr_mem_loader #(.NBITS(32), .MEM_DEPTH(256), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .bus          (bi.slave),
    .o_load_done  (done_b),
    .o_load_error (err_b),
    .o_word_count (cnt_b)
  );

  instr_mem_loader #(.NBITS(32), .MEM_DEPTH(4), .HALT_WORD(32'hFFFF_FFFF)) dut_s (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .bus          (si.slave),
    .o_load_done  (done_s),
    .o_load_error (err_s),
    .o_word_count (cnt_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the big instance: program image and residency flag.
  logic [31:0] model_mem [256];
  bit          model_done = 1'b0;

  function automatic logic [31:0] model_read(input logic [31:0] pc);
    if (!model_done) return 32'h0;
    if (pc >= 32'd1024) return HALT;
    return model_mem[int'(pc >> 2)];
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [31:0] pc, input logic [31:0] exp);
    bi.i_PC = pc;
    @(negedge clk);
    chk(name, bi.o_instruction, exp);
    chk({name, "_halt"}, 32'(bi.o_halt_fetched), 32'(exp == HALT));
  endtask

  // Presents one byte (after an idle gap) and holds it until accepted.
  task automatic send_byte(input int which, input logic [7:0] b, input int gap);
    int   tries;
    logic rdy;
    repeat (gap) align();
    if (which == 0) begin bi.i_byte = b; bi.i_byte_valid = 1'b1; end
    else            begin si.i_byte = b; si.i_byte_valid = 1'b1; end
    tries = 0;
    rdy = (which == 0) ? bi.o_byte_ready : si.o_byte_ready;
    while (!rdy && tries < 20) begin
      align();
      tries++;
      rdy = (which == 0) ? bi.o_byte_ready : si.o_byte_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout got=ready0 want=ready1");
    end
    align();
    if (which == 0) bi.i_byte_valid = 1'b0;
    else            si.i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input int which, input logic [31:0] w, input int maxgap);
    for (int b = 0; b < 4; b++) begin
      send_byte(which, w[31-8*b -: 8], int'($urandom_range(0, maxgap)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] wq [$];
    logic [31:0] w;
    logic [31:0] pc;
    logic [7:0]  stream [12];
    int          nb;
    logic        rdy;

    vecs[0] = '{32'h0000_0000, 32'h2008_0005, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0109_5020, 1'b0};
    vecs[2] = '{32'h0000_0008, HALT,          1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0109_5020, 1'b0};
    vecs[4] = '{32'h0000_0003, 32'h2008_0005, 1'b0};
    vecs[5] = '{32'h0000_0400, HALT,          1'b1};

    bi.i_load_en = 1'b0; bi.i_byte = '0; bi.i_byte_valid = 1'b0; bi.i_PC = '0;
    si.i_load_en = 1'b0; si.i_byte = '0; si.i_byte_valid = 1'b0; si.i_PC = '0;
    rst_n = 1'b1;

    // Reset asserted mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(bi.o_byte_ready), 32'd0);
    chk("rst_done",  32'(done_b), 32'd0);
    chk("rst_err",   32'(err_b), 32'd0);
    chk("rst_count", 32'(cnt_b), 32'd0);
    chk("rst_instr", bi.o_instruction, 32'h0);
    chk("rst_s_ready", 32'(si.o_byte_ready), 32'd0);
    #9 rst_n = 1'b1;
    align();

    // Normal load of a three-word program.
    bi.i_load_en = 1'b1;
    send_word(0, 32'h2008_0005, 0);
    send_word(0, 32'h0109_5020, 0);
    send_word(0, HALT, 0);
    align();
    chk("norm_count", 32'(cnt_b), 32'd3);
    chk("norm_done",  32'(done_b), 32'd1);
    chk("norm_err",   32'(err_b), 32'd0);
    bi.i_load_en = 1'b0;
    align();
    chk("norm_idle_ready", 32'(bi.o_byte_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      bi.i_PC = vecs[i].pc;
      @(negedge clk);
      chk($sformatf("vec%0d_instr", i), bi.o_instruction, vecs[i].instr);
      chk($sformatf("vec%0d_halt", i), 32'(bi.o_halt_fetched), 32'(vecs[i].halt));
    end

    // Backpressure: valid held high across the whole stream.
    for (int i = 0; i < 12; i++) stream[i] = (i < 8) ? 8'(i) : 8'hFF;
    align();
    bi.i_load_en = 1'b1;
    align();
    nb = 0;
    bi.i_byte = stream[0];
    bi.i_byte_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      rdy = bi.o_byte_ready;
      chk($sformatf("bp_ready_c%0d", c), 32'(rdy), 32'((c % 5) != 4));
      align();
      if (rdy) nb++;
      if (nb < 12) bi.i_byte = stream[nb];
      else         bi.i_byte_valid = 1'b0;
    end
    bi.i_byte_valid = 1'b0;
    chk("bp_count", 32'(cnt_b), 32'd3);
    chk("bp_done",  32'(done_b), 32'd1);
    bi.i_load_en = 1'b0;
    align();
    read_chk("bp_w0", 32'h0, 32'h0001_0203);
    read_chk("bp_w1", 32'h4, 32'h0405_0607);
    read_chk("bp_w2", 32'h8, HALT);

    // Abort after two bytes, then a clean restart.
    align();
    bi.i_load_en = 1'b1;
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'hBB, 0);
    bi.i_load_en = 1'b0;
    align();
    chk("abort_ready", 32'(bi.o_byte_ready), 32'd0);
    chk("abort_done",  32'(done_b), 32'd0);
    chk("abort_count", 32'(cnt_b), 32'd0);
    read_chk("abort_read", 32'h0, 32'h0);
    align();
    bi.i_load_en = 1'b1;
    send_word(0, 32'h1122_3344, 0);
    send_word(0, HALT, 0);
    align();
    chk("restart_count", 32'(cnt_b), 32'd2);
    chk("restart_done",  32'(done_b), 32'd1);
    bi.i_load_en = 1'b0;
    align();
    read_chk("restart_w0", 32'h0, 32'h1122_3344);
    read_chk("restart_w1", 32'h4, HALT);

    // Random programs with random byte gaps, checked against the model.
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(1, 10));
      wq.delete();
      align();
      model_done = 1'b0;
      bi.i_load_en = 1'b1;
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        wq.push_back(w);
        send_word(0, w, 2);
        if (k == 0) begin
          bi.i_PC = 32'h0;
          #1;
          chk("rnd_during_load", bi.o_instruction, model_read(32'h0));
        end
      end
      send_word(0, HALT, 2);
      align();
      for (int k = 0; k < n; k++) model_mem[k] = wq[k];
      model_mem[n] = HALT;
      model_done = 1'b1;
      chk("rnd_count", 32'(cnt_b), 32'(n + 1));
      chk("rnd_done",  32'(done_b), 32'd1);
      bi.i_load_en = 1'b0;
      align();
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 4) == 0) pc = $urandom | 32'h0000_0400;
        else                           pc = $urandom_range(0, (n + 1) * 4 - 1);
        read_chk("rnd_read", pc, model_read(pc));
      end
    end

    // Reset after the third byte of word 1.
    align();
    bi.i_load_en = 1'b1;
    bi.i_PC = 32'h0;
    send_word(0, 32'h1234_5678, 0);
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h02, 0);
    send_byte(0, 8'h03, 0);
    #2 rst_n = 1'b0;
    model_done = 1'b0;
    #1;
    chk("mrst_ready", 32'(bi.o_byte_ready), 32'd0);
    chk("mrst_done",  32'(done_b), 32'd0);
    chk("mrst_count", 32'(cnt_b), 32'd0);
    chk("mrst_instr", bi.o_instruction, model_read(32'h0));
    bi.i_load_en = 1'b0;
    #2 rst_n = 1'b1;
    align();
    read_chk("mrst_after", 32'h0, 32'h0);

    // Memory fills without HALT on the 4-word instance.
    align();
    si.i_load_en = 1'b1;
    for (int k = 0; k < 4; k++) send_word(1, 32'h0102_0300 + 32'(k), 0);
    align();
    chk("ovf_err",   32'(err_s), 32'd1);
    chk("ovf_done",  32'(done_s), 32'd0);
    chk("ovf_count", 32'(cnt_s), 32'd4);
    chk("ovf_ready", 32'(si.o_byte_ready), 32'd0);
    chk("ovf_instr", si.o_instruction, 32'h0);
    align();
    chk("ovf_hold_ready", 32'(si.o_byte_ready), 32'd0);
    chk("ovf_hold_err",   32'(err_s), 32'd1);
    si.i_load_en = 1'b0;
    align();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction memory for the fetch stage, directly downstream of the program counter.
- Consumes the current PC and returns the fetched instruction word.
- Includes a byte-stream loader FSM: the debug unit streams the program in byte-wise, and the block assembles the bytes into 32-bit words and writes them sequentially from address 0.
- The CPU fetches only after a load completes; the HALT word terminates the load.

Parameters:
- NBITS, 32, instruction/PC width.
- MEM_DEPTH, 256, number of instruction words.
- ADDR_BITS, $clog2(MEM_DEPTH), word-address width (derived, localparam).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that terminates load and execution.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_load_en  in  1  debug unit in program-load mode.
- i_byte  in  8  program byte from debug unit.
- i_byte_valid  in  1  i_byte valid.
- o_byte_ready  out  1  loader can accept a byte this cycle.
- i_PC  in  NBITS  current PC (byte address) from PC register.
- o_instruction  out  NBITS  fetched instruction.
- o_halt_fetched  out  1  o_instruction == HALT_WORD.
- o_load_done  out  1  sticky: a complete program terminated by HALT is resident.
- o_load_error  out  1  sticky: memory filled without HALT.
- o_word_count  out  ADDR_BITS+1  words written in current/last load.

Behaviour:
- Reset (async, i_reset_n=0):
  - FSM goes to IDLE.
  - byte index, word count, o_load_done and o_load_error clear to 0.
  - o_byte_ready = 0.
  - Memory array is not cleared.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - o_byte_ready = 0.
  - If i_load_en = 1 → LOAD; on that transition clear word count, byte index, o_load_done and o_load_error.
- LOAD:
  - o_byte_ready = 1. A byte is accepted on a posedge with i_byte_valid & o_byte_ready.
  - Byte order is big-endian: 1st byte → [31:24], 2nd → [23:16], 3rd → [15:8], 4th → [7:0].
  - After the 4th accepted byte → WRITE.
  - If i_load_en falls in LOAD: abort. Partial word discarded, → IDLE, o_load_done stays 0.
- WRITE (exactly one cycle):
  - o_byte_ready = 0; a byte presented this cycle is not consumed.
  - Writes mem[word_count] <= assembled word, word_count += 1, byte index reset.
  - If word == HALT_WORD → DONE, set o_load_done.
  - Else if the incremented count == MEM_DEPTH → DONE, set o_load_error (o_load_done stays 0).
  - Else → LOAD.
  - i_load_en is ignored in WRITE; the commit always completes.
- DONE:
  - o_byte_ready = 0.
  - → IDLE when i_load_en = 0. Flags and count are held.
- Per-word latency: 4 accepted bytes + 1 WRITE cycle. Peak throughput is 1 byte/cycle, with a 1-cycle bubble per word.
- Read path (combinational from i_PC; the PC register updates on negedge, so the read settles before the next posedge):
  - word address = i_PC[ADDR_BITS+1:2]; i_PC[1:0] ignored.
  - o_load_done = 0 → o_instruction = 0 (NOP). This covers during load, after an abort, after an error, and after reset.
  - Any i_PC[NBITS-1:ADDR_BITS+2] bit set → o_instruction = HALT_WORD, so a runaway PC stops the CPU.
  - Otherwise o_instruction = mem[word address].
  - o_halt_fetched = (o_instruction == HALT_WORD), combinational.
- Reset mid-load: immediate return to IDLE. Partial word lost. o_load_done = 0, so reads return NOP until a new load completes.

Decomposition:
- Shared package (mips_pkg):
  - HALT_WORD and NOP_WORD constants.
  - Loader state enum {IDLE, LOAD, WRITE, DONE}.
- Sub-module: instr_ram, a single-write-port, async-read word RAM (MEM_DEPTH × NBITS).
- The FSM, byte assembler and read mux stay in instr_mem_loader.

Test Plan:
- Reset values: assert i_reset_n=0 mid-cycle → o_byte_ready=0, o_load_done=0, o_load_error=0, o_word_count=0, o_instruction=0 for i_PC=0.
- Normal load:
  - Stimulus: stream 20 08 00 05, 01 09 50 20, FF FF FF FF, then drop i_load_en.
  - o_word_count=3, o_load_done=1.
  - i_PC=0 → 32'h2008_0005; i_PC=4 → 32'h0109_5020; i_PC=8 → HALT_WORD with o_halt_fetched=1; i_PC=5 → 32'h0109_5020.
- Backpressure:
  - Stimulus: hold i_byte_valid=1 continuously with byte sequence 0x00..0x07.
  - Each WRITE cycle shows o_byte_ready=0 and no byte is lost.
  - mem[0]=32'h0001_0203, mem[1]=32'h0405_0607.
- Abort and restart:
  - Stimulus: send 2 bytes, drop i_load_en.
  - FSM returns to IDLE, o_load_done=0, i_PC=0 reads 0.
  - A new full load then starts at word 0 with count cleared.
- Overflow (MEM_DEPTH=4): send 4 non-HALT words → o_load_error=1, o_load_done=0, o_word_count=4, o_byte_ready=0.
- Out-of-range PC and reset mid-load:
  - After a valid load, i_PC=32'h0000_0400 (depth 256) → HALT_WORD.
  - Assert reset after the 3rd byte of word 1 → IDLE, o_load_done=0, o_instruction=0.
